// File: rtl/maxterm_scanner.sv
// maxterm_scanner: serially loaded 2^N-entry truth table with direct lookup and a
// handshaked scan that counts the zero entries (maxterms).
// Latency: r is one cycle after x. A scan presents entry 0 on the cycle after start,
// and done pulses for one cycle after the last entry is transferred.
// Backpressure: without out_ready the scan holds out_idx/out_val. load/start are ignored while busy.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load, din           shift din into the table (IDLE only)
//   x, r                direct evaluation: r = T[x], registered
//   start               begin a scan (IDLE only, ignored when load is also high)
//   out_valid/out_ready scan entry handshake; out_idx/out_val = entry index/value
//   busy, done, zcount  not-IDLE flag, completion pulse, zero-entry count of last scan
module maxterm_scanner #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         din,
  input  logic [N-1:0] x,
  output logic         r,
  input  logic         start,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_idx,
  output logic         out_val,
  output logic         busy,
  output logic         done,
  output logic [N:0]   zcount
);

  localparam int DEPTH = 1 << N;
  localparam logic [N-1:0] LAST  = '1;
  localparam logic [N-1:0] ONE_C = 1;
  localparam logic [N:0]   ONE_Z = 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q;
  logic [DEPTH-1:0] t_q;
  logic [DEPTH-1:0] t_d;
  logic [N-1:0]     cnt_q;
  logic [N-1:0]     cnt_inc_d;
  logic             r_q;
  logic             out_valid_q;
  logic [N-1:0]     out_idx_q;
  logic             out_val_q;
  logic             busy_q;
  logic             done_q;
  logic [N:0]       zcount_q;

  // Table shifts toward index 0, so the first bit loaded ends at T[0].
  always_comb begin
    t_d       = t_q;
    cnt_inc_d = cnt_q + ONE_C;
    if (state_q == IDLE && load) begin
      t_d = {din, t_q[DEPTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      cnt_q       <= '0;
      r_q         <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_val_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      zcount_q    <= '0;
    end else begin
      // Lookup samples the table as it stood before this edge's shift.
      r_q <= t_q[x];
      case (state_q)
        IDLE: begin
          t_q    <= t_d;
          done_q <= 1'b0;
          if (start && !load) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            zcount_q    <= '0;
            out_valid_q <= 1'b1;
            out_idx_q   <= '0;
            out_val_q   <= t_q[0];
            busy_q      <= 1'b1;
          end
        end
        SCAN: begin
          if (out_valid_q && out_ready) begin
            if (!out_val_q) begin
              zcount_q <= zcount_q + ONE_Z;
            end
            if (cnt_q == LAST) begin
              // Last entry accepted: stop here rather than wrap into a second pass.
              state_q     <= DONE;
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              out_idx_q   <= '0;
              out_val_q   <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              cnt_q     <= cnt_inc_d;
              out_idx_q <= cnt_inc_d;
              out_val_q <= t_q[cnt_inc_d];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_idx_q   <= '0;
          out_val_q   <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign r         = r_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_val   = out_val_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign zcount    = zcount_q;

endmodule

// File: tb/tb_maxterm_scanner.sv
module tb_maxterm_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // N=3 instance
  logic       ld3 = 0, din3 = 0, start3 = 0, rdy3 = 0;
  logic [2:0] x3 = '0;
  logic       r3, ov3, val3, busy3, done3;
  logic [2:0] idx3;
  logic [3:0] zc3;

  // N=4 instance
  logic       ld4 = 0, din4 = 0, start4 = 0, rdy4 = 0;
  logic [3:0] x4 = '0;
  logic       r4, ov4, val4, busy4, done4;
  logic [3:0] idx4;
  logic [4:0] zc4;

  maxterm_scanner #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .load(ld3), .din(din3), .x(x3), .r(r3),
    .start(start3), .out_valid(ov3), .out_ready(rdy3), .out_idx(idx3),
    .out_val(val3), .busy(busy3), .done(done3), .zcount(zc3)
  );

  maxterm_scanner #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .load(ld4), .din(din4), .x(x4), .r(r4),
    .start(start4), .out_valid(ov4), .out_ready(rdy4), .out_idx(idx4),
    .out_val(val4), .busy(busy4), .done(done4), .zcount(zc4)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] x;
    logic       exp_r;
  } eval_vec_t;

  eval_vec_t  evals [6];
  logic [7:0] tbl;   // expected table, tbl[i] = value at index i
  logic [3:0] pat;   // out_ready pattern

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scan4(input logic [4:0] exp_z);
    int nvalid;
    bit seen;
    nvalid = 0;
    seen = 0;
    rdy4 = 1;
    start4 = 1;
    step();
    start4 = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ov4) nvalid++;
      if (done4) seen = 1;
      else step();
    end
    check("n4_done_seen", 32'(seen), 32'd1);
    check("n4_valid_cycles", 32'(nvalid), 32'd16);
    check("n4_zcount", 32'(zc4), 32'(exp_z));
    step();
  endtask

  initial begin
    bit   seen;
    int   expn;
    logic bits [8];

    bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl  = 8'b0101_1101;  // index 0 is LSB: 1,0,1,1,1,0,1,0
    pat  = 4'b1001;       // pat[c%4]: 1,0,0,1
    evals[0] = '{3'b101, 1'b0};
    evals[1] = '{3'b110, 1'b1};
    evals[2] = '{3'b000, 1'b1};
    evals[3] = '{3'b001, 1'b0};
    evals[4] = '{3'b011, 1'b1};
    evals[5] = '{3'b111, 1'b0};

    // Reset state
    step();
    step();
    check("rst_r", 32'(r3), 32'd0);
    check("rst_out_valid", 32'(ov3), 32'd0);
    check("rst_out_idx", 32'(idx3), 32'd0);
    check("rst_out_val", 32'(val3), 32'd0);
    check("rst_busy", 32'(busy3), 32'd0);
    check("rst_done", 32'(done3), 32'd0);
    check("rst_zcount", 32'(zc3), 32'd0);
    check("rst_zcount4", 32'(zc4), 32'd0);
    rst = 0;

    // Load 1,0,1,1,1,0,1,0
    for (int i = 0; i < 8; i++) begin
      ld3 = 1;
      din3 = bits[i];
      step();
    end
    ld3 = 0;
    din3 = 0;
    check("load_busy", 32'(busy3), 32'd0);

    // Direct evaluation vectors, one-cycle latency
    for (int i = 0; i < 6; i++) begin
      x3 = evals[i].x;
      step();
      check($sformatf("eval_r_x%0d", evals[i].x), 32'(r3), 32'(evals[i].exp_r));
    end
    // x=101 then 110: r must not change until the edge after x changes
    x3 = 3'b101;
    step();
    check("lat_r_101", 32'(r3), 32'd0);
    x3 = 3'b110;
    #2;
    check("lat_r_held", 32'(r3), 32'd0);
    step();
    check("lat_r_110", 32'(r3), 32'd1);

    // Full scan with out_ready=1; start pulsed again mid-scan must be ignored
    rdy3 = 1;
    start3 = 1;
    step();
    start3 = 0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("scan_valid_%0d", k), 32'(ov3), 32'd1);
      check($sformatf("scan_idx_%0d", k), 32'(idx3), 32'(k));
      check($sformatf("scan_val_%0d", k), 32'(val3), 32'(tbl[k]));
      check($sformatf("scan_done_lo_%0d", k), 32'(done3), 32'd0);
      start3 = (k == 3);
      step();
    end
    start3 = 0;
    check("scan_done_cycle9", 32'(done3), 32'd1);
    check("scan_done_valid", 32'(ov3), 32'd0);
    check("scan_done_busy", 32'(busy3), 32'd1);
    check("scan_zcount", 32'(zc3), 32'd3);
    step();
    check("scan_done_pulse_end", 32'(done3), 32'd0);
    check("scan_idle_busy", 32'(busy3), 32'd0);
    check("scan_zcount_hold", 32'(zc3), 32'd3);

    // Scan with out_ready toggling 1,0,0,1
    start3 = 1;
    step();
    start3 = 0;
    expn = 0;
    seen = 0;
    for (int c = 0; c < 64 && !seen; c++) begin
      if (done3) begin
        seen = 1;
        check("bp_done_valid", 32'(ov3), 32'd0);
      end else begin
        if (ov3) begin
          check("bp_idx", 32'(idx3), 32'(expn));
          check("bp_val", 32'(val3), 32'(tbl[expn[2:0]]));
        end
        rdy3 = pat[c % 4];
        if (rdy3 && ov3) expn++;
        step();
      end
    end
    check("bp_done_seen", 32'(seen), 32'd1);
    check("bp_entries", 32'(expn), 32'd8);
    check("bp_zcount", 32'(zc3), 32'd3);
    rdy3 = 1;
    step();

    // start and load together: load wins, table shifts, no scan
    ld3 = 1;
    din3 = 1;
    start3 = 1;
    step();
    ld3 = 0;
    din3 = 0;
    start3 = 0;
    check("sl_busy", 32'(busy3), 32'd0);
    x3 = 3'd0;
    step();
    check("sl_busy_after", 32'(busy3), 32'd0);
    check("sl_r_t0", 32'(r3), 32'd0);
    x3 = 3'd7;
    step();
    check("sl_r_t7", 32'(r3), 32'd1);

    // Reset at idx=4 mid-scan
    start3 = 1;
    step();
    start3 = 0;
    for (int k = 0; k < 4; k++) step();
    check("mid_idx4", 32'(idx3), 32'd4);
    rst = 1;
    #1;
    check("mid_rst_valid", 32'(ov3), 32'd0);
    check("mid_rst_busy", 32'(busy3), 32'd0);
    check("mid_rst_idx", 32'(idx3), 32'd0);
    check("mid_rst_zcount", 32'(zc3), 32'd0);
    step();
    check("mid_rst_done", 32'(done3), 32'd0);
    step();
    rst = 0;
    check("mid_rst_done2", 32'(done3), 32'd0);
    x3 = 3'd3;
    step();
    check("mid_rst_r_cleared", 32'(r3), 32'd0);
    start3 = 1;
    step();
    start3 = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done3) seen = 1;
      else step();
    end
    check("mid_rescan_done", 32'(seen), 32'd1);
    check("mid_rescan_zcount", 32'(zc3), 32'd8);
    step();

    // N=4: all ones then all zeros
    for (int i = 0; i < 16; i++) begin
      ld4 = 1;
      din4 = 1;
      step();
    end
    ld4 = 0;
    scan4(5'd0);
    for (int i = 0; i < 16; i++) begin
      ld4 = 1;
      din4 = 0;
      step();
    end
    ld4 = 0;
    scan4(5'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
